// File: rtl/axi2array_frame_gen.sv
// axi2array_frame_gen: turns simplified AXI burst commands (plus 256-bit write
// beats) into a serial stream of 89-bit array frames, one frame per 64-bit word.
// Frame layout: [21:0] {row,col} address, [85:22] data, [86] rw, [87] sof, [88] eof.
module axi2array_frame_gen #(
  parameter int ARRAY_COL_ADDR_WIDTH   = 6,
  parameter int ARRAY_ROW_ADDR_WIDTH   = 16,
  parameter int ARRAY_DATA_WIDTH       = 64,
  parameter int AXI_DATA_WIDTH         = 4 * ARRAY_DATA_WIDTH,
  parameter int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           mc_en,
  input  logic                                           axi_cmd_valid,
  output logic                                           axi_cmd_ready,
  input  logic                                           axi_cmd_write,
  input  logic [ARRAY_ROW_ADDR_WIDTH+ARRAY_COL_ADDR_WIDTH-1:0] axi_cmd_addr,
  input  logic [7:0]                                     axi_cmd_len,
  input  logic                                           axi_wdata_valid,
  output logic                                           axi_wdata_ready,
  input  logic [AXI_DATA_WIDTH-1:0]                      axi_wdata,
  input  logic                                           axi_wlast,
  output logic                                           axi2array_frame_valid,
  output logic [ARRAY_FRAME_DATA_WIDTH-1:0]              axi2array_frame_data,
  input  logic                                           axi2array_frame_ready,
  output logic                                           burst_done,
  output logic                                           wlast_err
);

  localparam int AW = ARRAY_ROW_ADDR_WIDTH + ARRAY_COL_ADDR_WIDTH;
  localparam int DW = ARRAY_DATA_WIDTH;
  localparam int FW = ARRAY_FRAME_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [9:0]                fcnt_q, fcnt_d;
  logic [7:0]                beat_q, beat_d;
  logic [AXI_DATA_WIDTH-1:0] buf_q, buf_d;
  logic                      buf_vld_q, buf_vld_d;
  // all four sub-words of the buffered beat have entered the frame register
  logic                      buf_sent_q, buf_sent_d;
  // the eof frame has entered the frame register; generator stops
  logic                      last_ld_q, last_ld_d;
  logic                      frame_valid_q, frame_valid_d;
  logic [FW-1:0]             frame_data_q, frame_data_d;
  logic                      burst_done_q, burst_done_d;
  logic                      wlast_err_q, wlast_err_d;

  logic                      cmd_hs_s, wd_hs_s, frame_hs_s, eof_hs_s;
  logic                      src_avail_s, src_rw_s, src_sof_s, src_eof_s, load_s;
  logic [AW-1:0]             src_base_s, src_addr_s;
  logic [7:0]                src_len_s;
  logic [9:0]                src_fcnt_s;
  logic [DW-1:0]             src_word_s;
  logic [FW-1:0]             src_frame_s;

  assign axi_cmd_ready         = (state_q == ST_IDLE) && mc_en && !rst;
  assign axi_wdata_ready       = (state_q == ST_WR) && !buf_vld_q && !rst;
  assign axi2array_frame_valid = frame_valid_q;
  assign axi2array_frame_data  = frame_data_q;
  assign burst_done            = burst_done_q;
  assign wlast_err             = wlast_err_q;

  assign cmd_hs_s   = axi_cmd_valid && axi_cmd_ready;
  assign wd_hs_s    = axi_wdata_valid && axi_wdata_ready;
  assign frame_hs_s = frame_valid_q && axi2array_frame_ready;
  assign eof_hs_s   = frame_hs_s && frame_data_q[FW-1];

  // Frame source: picks where the next frame comes from. The first read frame is
  // built straight from the command and the first frame of each write beat straight
  // from the bus, so both appear the cycle after their handshake.
  always_comb begin
    src_avail_s = 1'b0;
    src_base_s  = addr_q;
    src_len_s   = len_q;
    src_fcnt_s  = fcnt_q;
    src_rw_s    = 1'b0;
    src_word_s  = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        src_base_s  = axi_cmd_addr;
        src_len_s   = axi_cmd_len;
        src_fcnt_s  = 10'd0;
        src_avail_s = cmd_hs_s && !axi_cmd_write;
      end
      ST_RD: begin
        src_avail_s = !last_ld_q;
      end
      ST_WR: begin
        src_rw_s = 1'b1;
        if (buf_vld_q) begin
          src_avail_s = !buf_sent_q;
          case (fcnt_q[1:0])
            2'd0:    src_word_s = buf_q[DW-1:0];
            2'd1:    src_word_s = buf_q[2*DW-1:DW];
            2'd2:    src_word_s = buf_q[3*DW-1:2*DW];
            2'd3:    src_word_s = buf_q[4*DW-1:3*DW];
            default: src_word_s = {DW{1'b0}};
          endcase
        end else begin
          src_avail_s = wd_hs_s;
          src_word_s  = axi_wdata[DW-1:0];
        end
      end
      default: begin
        src_avail_s = 1'b0;
      end
    endcase
  end

  assign src_addr_s  = src_base_s + {{(AW-10){1'b0}}, src_fcnt_s};
  assign src_sof_s   = (src_fcnt_s == 10'd0);
  assign src_eof_s   = (src_fcnt_s == {src_len_s, 2'b11});
  assign src_frame_s = {src_eof_s, src_sof_s, src_rw_s, src_word_s, src_addr_s};
  assign load_s      = src_avail_s && (!frame_valid_q || axi2array_frame_ready);

  // Next-state logic: burst FSM, counters, beat buffer, frame register and flags.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    fcnt_d        = fcnt_q;
    beat_d        = beat_q;
    buf_d         = buf_q;
    buf_vld_d     = buf_vld_q;
    buf_sent_d    = buf_sent_q;
    last_ld_d     = last_ld_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    burst_done_d  = eof_hs_s;
    wlast_err_d   = wlast_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          state_d    = axi_cmd_write ? ST_WR : ST_RD;
          addr_d     = axi_cmd_addr;
          len_d      = axi_cmd_len;
          fcnt_d     = 10'd0;
          beat_d     = 8'd0;
          buf_vld_d  = 1'b0;
          buf_sent_d = 1'b0;
          last_ld_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR, ST_RD: begin
        if (eof_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wd_hs_s) begin
      buf_d      = axi_wdata;
      buf_vld_d  = 1'b1;
      buf_sent_d = 1'b0;
      beat_d     = beat_q + 8'd1;
      if (axi_wlast != (beat_q == len_q)) begin
        wlast_err_d = 1'b1;
      end else begin
        wlast_err_d = wlast_err_q;
      end
    end else if (frame_hs_s && (state_q == ST_WR) && buf_sent_q) begin
      buf_vld_d  = 1'b0;
      buf_sent_d = 1'b0;
    end else begin
      buf_vld_d = buf_vld_q;
    end

    if (load_s) begin
      frame_valid_d = 1'b1;
      frame_data_d  = src_frame_s;
      fcnt_d        = src_fcnt_s + 10'd1;
      if (src_eof_s) begin
        last_ld_d = 1'b1;
      end else begin
        last_ld_d = last_ld_d;
      end
      if ((state_q == ST_WR) && (src_fcnt_s[1:0] == 2'b11)) begin
        buf_sent_d = 1'b1;
      end else begin
        buf_sent_d = buf_sent_d;
      end
    end else if (axi2array_frame_ready) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= {AW{1'b0}};
      len_q         <= 8'd0;
      fcnt_q        <= 10'd0;
      beat_q        <= 8'd0;
      buf_q         <= {AXI_DATA_WIDTH{1'b0}};
      buf_vld_q     <= 1'b0;
      buf_sent_q    <= 1'b0;
      last_ld_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= {FW{1'b0}};
      burst_done_q  <= 1'b0;
      wlast_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      fcnt_q        <= fcnt_d;
      beat_q        <= beat_d;
      buf_q         <= buf_d;
      buf_vld_q     <= buf_vld_d;
      buf_sent_q    <= buf_sent_d;
      last_ld_q     <= last_ld_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      burst_done_q  <= burst_done_d;
      wlast_err_q   <= wlast_err_d;
    end
  end

endmodule

// File: tb/tb_axi2array_frame_gen.sv
// Scoreboard bench for axi2array_frame_gen: stimulus pushes expected frames,
// a negedge monitor pops and compares on every frame handshake.
module tb_axi2array_frame_gen;

  logic         clk = 1'b0;
  logic         rst, mc_en, cmd_valid, cmd_write, cmd_ready;
  logic [21:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic         wd_valid, wd_ready, wlast;
  logic [255:0] wdata;
  logic         f_valid, f_ready, burst_done, wlast_err;
  logic [88:0]  f_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [88:0] sb_q[$];
  bit bypass = 1'b0;
  bit tog_mode = 1'b0;
  bit prev_eof_hs = 1'b0;
  bit prev_stall = 1'b0;
  logic [88:0] prev_data;

  axi2array_frame_gen dut (
    .clk(clk), .rst(rst), .mc_en(mc_en),
    .axi_cmd_valid(cmd_valid), .axi_cmd_ready(cmd_ready), .axi_cmd_write(cmd_write),
    .axi_cmd_addr(cmd_addr), .axi_cmd_len(cmd_len),
    .axi_wdata_valid(wd_valid), .axi_wdata_ready(wd_ready), .axi_wdata(wdata), .axi_wlast(wlast),
    .axi2array_frame_valid(f_valid), .axi2array_frame_data(f_data), .axi2array_frame_ready(f_ready),
    .burst_done(burst_done), .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [63:0] word_of(input int pat, input int b, input int w);
    return (pat == 0) ? 64'd1 : {32'hA5A5_0000 | 32'(b), 32'(w)};
  endfunction

  function automatic logic [255:0] beat_data(input int pat, input int b);
    logic [255:0] r;
    for (int w = 0; w < 4; w++) r[w*64 +: 64] = word_of(pat, b, w);
    return r;
  endfunction

  function automatic logic [88:0] mkf(input logic [21:0] base, input int i, input int len,
                                      input bit rw, input logic [63:0] d);
    logic [21:0] a;
    a = base + 22'(i);
    return {(i == (len + 1) * 4 - 1) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, rw,
            rw ? d : 64'd0, a};
  endfunction

  // frame_ready driver: steady level or toggling every cycle
  initial begin
    f_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) f_ready = ~f_ready;
      else f_ready = 1'b1;
    end
  end

  // monitor: scoreboard pop on handshake, stall stability, burst_done timing
  always @(negedge clk) begin : mon
    logic [88:0] e;
    if (rst) begin
      prev_eof_hs = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      chk("burst_done_timing", burst_done, prev_eof_hs);
      if (burst_done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", f_valid, 1'b1);
        chk("stall_data", f_data, prev_data);
      end
      prev_stall  = f_valid && !f_ready;
      prev_data   = f_data;
      prev_eof_hs = f_valid && f_ready && f_data[88];
      if (f_valid && f_ready) begin
        if (bypass) begin
          chk("no_eof_after_reset", f_data[88], 1'b0);
        end else if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got %0h expected none", f_data);
        end else begin
          e = sb_q.pop_front();
          chk("frame", f_data, e);
        end
      end
    end
  end

  task automatic do_cmd(input bit wr, input logic [21:0] a, input logic [7:0] l);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
    if (!cmd_ready) timeout("cmd_handshake");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (!wr) begin
      chk("rd_first_valid", f_valid, 1'b1);
      chk("rd_first_sof", f_data[87], 1'b1);
    end
  endtask

  task automatic do_beat(input logic [255:0] d, input bit last, input bit first);
    int n = 0;
    @(posedge clk); #1;
    wd_valid = 1'b1; wdata = d; wlast = last;
    @(negedge clk);
    while (!wd_ready && n < 200) begin n++; @(negedge clk); end
    if (!wd_ready) timeout("wdata_handshake");
    @(posedge clk); #1;
    wd_valid = 1'b0;
    @(negedge clk);
    if (first) chk("wr_first_valid", f_valid, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || f_valid) && n < 3000) begin n++; @(negedge clk); end
    if (sb_q.size() != 0 || f_valid) timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_burst(input logic [21:0] a, input int len, input int pat, input int bad_beat);
    for (int i = 0; i < (len + 1) * 4; i++) sb_q.push_back(mkf(a, i, len, 1'b1, word_of(pat, i / 4, i % 4)));
    do_cmd(1'b1, a, 8'(len));
    for (int b = 0; b <= len; b++)
      do_beat(beat_data(pat, b), (bad_beat < 0) ? (b == len) : (b == bad_beat), b == 0);
    drain();
  endtask

  task automatic rd_push(input logic [21:0] a, input int len);
    for (int i = 0; i < (len + 1) * 4; i++) sb_q.push_back(mkf(a, i, len, 1'b0, 64'd0));
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b1; mc_en = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 22'd0;
    cmd_len = 8'd0; wd_valid = 1'b0; wdata = 256'd0; wlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wdata_ready", wd_ready, 1'b0);
    chk("rst_frame_valid", f_valid, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_wlast_err", wlast_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // write len 16, all words 1
    d0 = done_cnt;
    wr_burst(22'd0, 16, 0, -1);
    chk("wr_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("wr_wlast_err", wlast_err, 1'b0);

    // read len 32
    d0 = done_cnt;
    rd_push(22'd0, 32);
    do_cmd(1'b0, 22'd0, 8'd32);
    drain();
    chk("rd_done_cnt", 32'(done_cnt - d0), 32'd1);

    // backpressure: write len 0 with ready toggling
    tog_mode = 1'b1;
    wr_burst(22'h100, 0, 1, -1);
    tog_mode = 1'b0;

    // address wrap, with mc_en dropped mid-burst
    d0 = done_cnt;
    rd_push(22'h3FFFFE, 0);
    do_cmd(1'b0, 22'h3FFFFE, 8'd0);
    mc_en = 1'b0;
    drain();
    chk("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("mcen_low_cmd_ready", cmd_ready, 1'b0);

    // gating: no command accepted while mc_en low
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'h55; cmd_len = 8'd0;
    repeat (5) begin
      @(negedge clk);
      chk("gated_cmd_ready", cmd_ready, 1'b0);
      chk("gated_no_frame", f_valid, 1'b0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    mc_en = 1'b1;

    // wlast error: len 1 with wlast on beat 0
    d0 = done_cnt;
    wr_burst(22'h200, 1, 1, 0);
    chk("wlast_err_set", wlast_err, 1'b1);
    chk("wlast_done_cnt", 32'(done_cnt - d0), 32'd1);

    // reset at frame 5 of a len 3 write
    bypass = 1'b1;
    do_cmd(1'b1, 22'h40, 8'd3);
    do_beat(beat_data(1, 0), 1'b0, 1'b1);
    do_beat(beat_data(1, 1), 1'b0, 1'b0);
    n = 0;
    while (!(f_valid && f_data[21:0] == 22'h45) && n < 100) begin n++; @(negedge clk); end
    if (!(f_valid && f_data[21:0] == 22'h45)) timeout("frame5");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", f_valid, 1'b0);
    chk("mid_rst_burst_done", burst_done, 1'b0);
    chk("mid_rst_wlast_err", wlast_err, 1'b0);
    chk("mid_rst_wdata_ready", wd_ready, 1'b0);
    rst = 1'b0;
    bypass = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", cmd_ready, 1'b1);
    chk("post_rst_no_frame", f_valid, 1'b0);
    rd_push(22'h80, 0);
    do_cmd(1'b0, 22'h80, 8'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
